// File: rtl/mycpu_pkg.sv
// Shared I/O definitions: register address map and STAT bit positions.
package mycpu_pkg;

   typedef enum logic [2:0] {
      IO_STAT  = 3'd0,
      IO_DATA  = 3'd1,
      IO_GPO   = 3'd2,
      IO_GPI   = 3'd3,
      IO_IRQEN = 3'd4
   } io_addr_t;

   localparam int ST_RXE   = 0;
   localparam int ST_RXF   = 1;
   localparam int ST_TXE   = 2;
   localparam int ST_TXF   = 3;
   localparam int ST_TXOVF = 4;
   localparam int ST_RXUDF = 5;
   localparam int ST_W     = 6;

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO. The head reads 0 while empty, so callers can
// forward it without extra gating. A push is accepted when full only if a pop
// happens in the same cycle.
module io_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [AW:0]       count;
   logic              do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rptr];

   // Storage array; contents need no reset because head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_port.sv
// CPU-facing I/O responder: decodes IOR/IOW cycles onto a TX FIFO, an RX FIFO,
// a GPO latch and a synchronised GPI port. Reads are combinational.
// Optional feature macro: IO_IRQ_EN (IRQEN register at address 4 and irq_out).
module io_port
   import mycpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int GPI_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iom_in,
   input  logic              wen_in,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] tx_data_out,
   output logic              tx_valid_out,
   input  logic              tx_ready_in,
   input  logic [DATA_W-1:0] rx_data_in,
   input  logic              rx_valid_in,
   output logic              rx_ready_out,
   input  logic [GPI_W-1:0]  gpi_in,
   output logic [GPI_W-1:0]  gpo_out,
   output logic              irq_out
);

   logic              wr, rd;
   logic [2:0]        sel;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [DATA_W-1:0] rx_head;
   logic              tx_ovf, rx_udf;
   logic [GPI_W-1:0]  gpi_s1, gpi_s2;
   logic [ST_W-1:0]   stat;
   logic              unused_addr;

   assign wr  = iom_in & ~wen_in;
   assign rd  = iom_in & wen_in;
   assign sel = addr_in[2:0];
   assign unused_addr = ^addr_in[DATA_W-1:3];

   assign tx_push      = wr & (sel == IO_DATA);
   assign tx_pop       = tx_valid_out & tx_ready_in;
   assign tx_valid_out = ~tx_empty;
   assign rx_pop       = rd & (sel == IO_DATA);
   assign rx_ready_out = ~rx_full;
   assign rx_push      = rx_valid_in & rx_ready_out;

   io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
      .clk(clk), .rst_n(rst_n), .push(tx_push), .wdata(data_in), .pop(tx_pop),
      .head(tx_data_out), .full(tx_full), .empty(tx_empty)
   );

   io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
      .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_data_in), .pop(rx_pop),
      .head(rx_head), .full(rx_full), .empty(rx_empty)
   );

   // Sticky error flags: set on dropped write / empty read, cleared by any STAT write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_ovf <= 1'b0;
         rx_udf <= 1'b0;
      end else if (wr && sel == IO_STAT) begin
         tx_ovf <= 1'b0;
         rx_udf <= 1'b0;
      end else begin
         if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
         if (rx_pop && rx_empty)            rx_udf <= 1'b1;
      end
   end

   // GPO latch written from the low data bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     gpo_out <= '0;
      else if (wr && sel == IO_GPO)   gpo_out <= data_in[GPI_W-1:0];
   end

   // Two-flop synchroniser for the asynchronous GPI pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpi_s1 <= '0;
         gpi_s2 <= '0;
      end else begin
         gpi_s1 <= gpi_in;
         gpi_s2 <= gpi_s1;
      end
   end

   // STAT word assembled from live FIFO state and sticky flags.
   always_comb begin
      stat           = '0;
      stat[ST_RXE]   = rx_empty;
      stat[ST_RXF]   = rx_full;
      stat[ST_TXE]   = tx_empty;
      stat[ST_TXF]   = tx_full;
      stat[ST_TXOVF] = tx_ovf;
      stat[ST_RXUDF] = rx_udf;
   end

`ifdef IO_IRQ_EN
   logic [2:0] irqen;   // {ovf_ie, tx_empty_ie, rx_avail_ie}

   // Interrupt enables and registered interrupt; it drops once its source clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irqen   <= '0;
         irq_out <= 1'b0;
      end else begin
         if (wr && sel == IO_IRQEN) irqen <= data_in[2:0];
         irq_out <= (irqen[0] & ~rx_empty) | (irqen[1] & tx_empty) |
                    (irqen[2] & (tx_ovf | rx_udf));
      end
   end
`else
   assign irq_out = 1'b0;
`endif

   // Zero-latency read mux; idle and write cycles return 0.
   always_comb begin
      data_out = '0;
      if (rd) begin
         case (sel)
            IO_STAT:  data_out[ST_W-1:0]  = stat;
            IO_DATA:  data_out            = rx_head;
            IO_GPO:   data_out[GPI_W-1:0] = gpo_out;
            IO_GPI:   data_out[GPI_W-1:0] = gpi_s2;
`ifdef IO_IRQ_EN
            IO_IRQEN: data_out[2:0]       = irqen;
`endif
            default:  data_out            = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port (DATA_W=16, DEPTH=4, GPI_W=8). Inputs change on
// the falling edge; outputs are sampled in the low phase.
module tb_io_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iom_in, wen_in;
   logic [15:0] addr_in, data_in, data_out, tx_data_out, rx_data_in;
   logic        tx_valid_out, tx_ready_in, rx_valid_in, rx_ready_out, irq_out;
   logic [7:0]  gpi_in, gpo_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_port #(.DATA_W(16), .DEPTH(4), .GPI_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .iom_in(iom_in), .wen_in(wen_in),
      .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
      .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
      .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in), .rx_ready_out(rx_ready_out),
      .gpi_in(gpi_in), .gpo_out(gpo_out), .irq_out(irq_out)
   );

   // one IOW cycle spanning exactly one rising edge
   task automatic iow(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      iom_in = 1'b1; wen_in = 1'b0; addr_in = {13'b0, a}; data_in = d;
      @(negedge clk);
      iom_in = 1'b0; wen_in = 1'b1;
   endtask

   // one IOR cycle; returns data_out sampled before the edge that applies side effects
   task automatic ior(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      iom_in = 1'b1; wen_in = 1'b1; addr_in = {13'b0, a};
      #1 d = data_out;
      @(negedge clk);
      iom_in = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; iom_in = 1'b0; wen_in = 1'b1; addr_in = '0; data_in = '0;
      tx_ready_in = 1'b0; rx_data_in = '0; rx_valid_in = 1'b0; gpi_in = '0;
      #1;
      checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid_out); end
      checks++; if (tx_data_out !== 16'h0) begin errors++; $display("FAIL rst_tx_data got %h exp 0000", tx_data_out); end
      checks++; if (rx_ready_out !== 1'b1) begin errors++; $display("FAIL rst_rx_ready got %b exp 1", rx_ready_out); end
      checks++; if (gpo_out !== 8'h00) begin errors++; $display("FAIL rst_gpo got %h exp 00", gpo_out); end
      checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq_out); end
      checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL rst_data_idle got %h exp 0000", data_out); end
      iom_in = 1'b1;
      #1;
      checks++; if (data_out !== 16'h0005) begin errors++; $display("FAIL rst_stat got %h exp 0005", data_out); end
      iom_in = 1'b0;
      #12 rst_n = 1'b1;
   endtask

   task automatic test_tx;
      logic [15:0] d;
      iow(3'd1, 16'hA5A5);
      iow(3'd1, 16'h1234);
      checks++; if (tx_valid_out !== 1'b1) begin errors++; $display("FAIL tx_valid got %b exp 1", tx_valid_out); end
      checks++; if (tx_data_out !== 16'hA5A5) begin errors++; $display("FAIL tx_head0 got %h exp a5a5", tx_data_out); end
      tx_ready_in = 1'b1;
      @(negedge clk);
      checks++; if (tx_data_out !== 16'h1234) begin errors++; $display("FAIL tx_head1 got %h exp 1234", tx_data_out); end
      @(negedge clk);
      checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL tx_drained got %b exp 0", tx_valid_out); end
      tx_ready_in = 1'b0;
      ior(3'd0, d);
      checks++; if (d !== 16'h0005) begin errors++; $display("FAIL tx_stat_idle got %h exp 0005", d); end
   endtask

   task automatic test_tx_overflow;
      logic [15:0] d;
      logic [15:0] exp [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      for (int i = 0; i < 4; i++) iow(3'd1, exp[i]);
      iow(3'd1, 16'h0055);
      ior(3'd0, d);
      checks++; if (d !== 16'h0019) begin errors++; $display("FAIL ovf_stat got %h exp 0019", d); end
      iow(3'd0, 16'hFFFF);
      ior(3'd0, d);
      checks++; if (d !== 16'h0009) begin errors++; $display("FAIL ovf_clear got %h exp 0009", d); end
      tx_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (tx_data_out !== exp[i]) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, tx_data_out, exp[i]); end
         @(negedge clk);
      end
      checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", tx_valid_out); end
      tx_ready_in = 1'b0;
   endtask

   task automatic test_tx_full_push_pop;
      logic [15:0] d;
      logic [15:0] exp [4] = '{16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05};
      iow(3'd1, 16'h0B01);
      for (int i = 0; i < 3; i++) iow(3'd1, exp[i]);
      @(negedge clk);
      iom_in = 1'b1; wen_in = 1'b0; addr_in = 16'd1; data_in = exp[3]; tx_ready_in = 1'b1;
      @(negedge clk);
      iom_in = 1'b0; wen_in = 1'b1; tx_ready_in = 1'b0;
      ior(3'd0, d);
      checks++; if (d !== 16'h0009) begin errors++; $display("FAIL fpp_stat got %h exp 0009", d); end
      tx_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (tx_data_out !== exp[i]) begin errors++; $display("FAIL fpp_drain%0d got %h exp %h", i, tx_data_out, exp[i]); end
         @(negedge clk);
      end
      tx_ready_in = 1'b0;
   endtask

   task automatic test_rx;
      logic [15:0] d;
      rx_valid_in = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         rx_data_in = 16'(i);
         #1;
         checks++; if (rx_ready_out !== 1'b1) begin errors++; $display("FAIL rx_ready%0d got %b exp 1", i, rx_ready_out); end
         @(negedge clk);
      end
      checks++; if (rx_ready_out !== 1'b0) begin errors++; $display("FAIL rx_full_ready got %b exp 0", rx_ready_out); end
      rx_data_in = 16'h0099;
      @(negedge clk);
      rx_valid_in = 1'b0;
      ior(3'd0, d);
      checks++; if (d !== 16'h0006) begin errors++; $display("FAIL rx_stat_full got %h exp 0006", d); end
      for (int i = 1; i <= 4; i++) begin
         ior(3'd1, d);
         checks++; if (d !== 16'(i)) begin errors++; $display("FAIL rx_read%0d got %h exp %h", i, d, 16'(i)); end
      end
      ior(3'd1, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rx_udf_data got %h exp 0000", d); end
      ior(3'd0, d);
      checks++; if (d !== 16'h0025) begin errors++; $display("FAIL rx_udf_stat got %h exp 0025", d); end
      iow(3'd0, 16'h0000);
      // STAT polled over several edges must not change
      @(negedge clk);
      iom_in = 1'b1; wen_in = 1'b1; addr_in = 16'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (data_out !== 16'h0005) begin errors++; $display("FAIL poll%0d got %h exp 0005", i, data_out); end
         @(negedge clk);
      end
      iom_in = 1'b0;
      // push and pop in the same cycle on a partly filled RX FIFO
      rx_valid_in = 1'b1; rx_data_in = 16'hAAAA;
      @(negedge clk);
      rx_data_in = 16'hBBBB; iom_in = 1'b1; wen_in = 1'b1; addr_in = 16'd1;
      #1;
      checks++; if (data_out !== 16'hAAAA) begin errors++; $display("FAIL rx_pp_a got %h exp aaaa", data_out); end
      @(negedge clk);
      rx_valid_in = 1'b0; iom_in = 1'b0;
      ior(3'd1, d);
      checks++; if (d !== 16'hBBBB) begin errors++; $display("FAIL rx_pp_b got %h exp bbbb", d); end
      ior(3'd0, d);
      checks++; if (d !== 16'h0005) begin errors++; $display("FAIL rx_pp_stat got %h exp 0005", d); end
   endtask

   task automatic test_gpio;
      logic [15:0] d;
      @(negedge clk);
      gpi_in = 8'h3C; iom_in = 1'b1; wen_in = 1'b1; addr_in = 16'd3;
      #1;
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL gpi_e0 got %h exp 0000", data_out); end
      @(negedge clk);
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL gpi_e1 got %h exp 0000", data_out); end
      @(negedge clk);
      checks++; if (data_out !== 16'h003C) begin errors++; $display("FAIL gpi_e2 got %h exp 003c", data_out); end
      @(negedge clk);
      checks++; if (data_out !== 16'h003C) begin errors++; $display("FAIL gpi_e3 got %h exp 003c", data_out); end
      iom_in = 1'b0;
      iow(3'd2, 16'h00FF);
      checks++; if (gpo_out !== 8'hFF) begin errors++; $display("FAIL gpo got %h exp ff", gpo_out); end
      ior(3'd2, d);
      checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL gpo_rd got %h exp 00ff", d); end
      iow(3'd5, 16'hFFFF);
      checks++; if (gpo_out !== 8'hFF) begin errors++; $display("FAIL addr5_gpo got %h exp ff", gpo_out); end
      ior(3'd5, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL addr5_rd got %h exp 0000", d); end
      ior(3'd4, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL addr4_rd got %h exp 0000", d); end
      ior(3'd0, d);
      checks++; if (d !== 16'h0005) begin errors++; $display("FAIL addr5_stat got %h exp 0005", d); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] d;
      for (int i = 0; i < 5; i++) iow(3'd1, 16'(16'hC000 + i));
      rx_valid_in = 1'b1; rx_data_in = 16'h7777;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      rx_valid_in = 1'b0;
      #1;
      checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL mid_tx_valid got %b exp 0", tx_valid_out); end
      checks++; if (tx_data_out !== 16'h0) begin errors++; $display("FAIL mid_tx_data got %h exp 0000", tx_data_out); end
      checks++; if (gpo_out !== 8'h00) begin errors++; $display("FAIL mid_gpo got %h exp 00", gpo_out); end
      iom_in = 1'b1; wen_in = 1'b1; addr_in = 16'd0;
      #1;
      checks++; if (data_out !== 16'h0005) begin errors++; $display("FAIL mid_stat got %h exp 0005", data_out); end
      addr_in = 16'd3;
      #1;
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL mid_gpi got %h exp 0000", data_out); end
      iom_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ior(3'd0, d);
      checks++; if (d !== 16'h0005) begin errors++; $display("FAIL post_stat got %h exp 0005", d); end
   endtask

`ifdef IO_IRQ_EN
   task automatic test_irq;
      logic [15:0] d;
      iow(3'd4, 16'h0001);
      checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq_out); end
      rx_valid_in = 1'b1; rx_data_in = 16'h0042;
      @(negedge clk);
      rx_valid_in = 1'b0;
      @(negedge clk);
      checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq_out); end
      ior(3'd1, d);
      checks++; if (d !== 16'h0042) begin errors++; $display("FAIL irq_data got %h exp 0042", d); end
      @(negedge clk);
      checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq_out); end
      ior(3'd4, d);
      checks++; if (d !== 16'h0001) begin errors++; $display("FAIL irqen_rd got %h exp 0001", d); end
   endtask
`endif

   initial begin
      test_reset();
      test_tx();
      test_tx_overflow();
      test_tx_full_push_pop();
      test_rx();
      test_gpio();
      test_reset_mid();
`ifdef IO_IRQ_EN
      test_irq();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
